// File: rtl/osc_cmd_pkg.sv
// Shared definitions for the command dispatcher: FSM encoding, reply bytes
// and the opcode of the first configuration slot.
package osc_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_DISPATCH = 3'd1;
  localparam state_t ST_RELEASE  = 3'd2;
  localparam state_t ST_ABORT    = 3'd3;
  localparam state_t ST_ACK      = 3'd4;

  localparam logic [7:0] OPCODE_BASE = 8'h01;
  localparam logic [7:0] ACK_OK      = 8'hAA;
  localparam logic [7:0] ACK_ERR     = 8'hEE;

  // Width of the per-command inactivity counter.
  localparam int TMR_W = 24;

endpackage

// File: rtl/cmd_dispatch_if.sv
// Bus bundle between the UART side, the configuration slots and the reply
// transmitter; the dispatcher connects through the slave modport.
interface cmd_dispatch_if #(
  parameter int N_SLOTS = 4
);
  // rx_ready and sub_rx_ready are single-cycle strobes with no back-pressure.
  // tx_valid/tx_data stay stable until a cycle with tx_ready high; the reply
  // is transferred on that clock edge and tx_valid drops on the next cycle.
  logic [7:0]         rx_data;
  logic               rx_ready;
  logic [N_SLOTS-1:0] sub_activate;
  logic [N_SLOTS-1:0] sub_done;
  logic [7:0]         sub_rx_data;
  logic               sub_rx_ready;
  logic [N_SLOTS-1:0] sub_rst_n;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport slave (
    input  rx_data, rx_ready, sub_done, tx_ready,
    output sub_activate, sub_rx_data, sub_rx_ready, sub_rst_n, tx_data, tx_valid
  );

  modport master (
    output rx_data, rx_ready, sub_done, tx_ready,
    input  sub_activate, sub_rx_data, sub_rx_ready, sub_rst_n, tx_data, tx_valid
  );

endinterface

// File: rtl/cmd_timeout.sv
// Saturating inactivity counter; expired flags the last allowed idle cycle
// while counting is enabled.
module cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  import osc_cmd_pkg::*;

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Clear has priority so a forwarded byte restarts the window immediately.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/cmd_dispatch.sv
// UART command dispatcher: decodes an opcode, hands the following bytes to
// one configuration slot and answers with an OK/ERR reply byte.
module cmd_dispatch #(
  parameter int         N_SLOTS        = 4,
  parameter logic [7:0] OPCODE_BASE    = osc_cmd_pkg::OPCODE_BASE,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] ACK_OK         = osc_cmd_pkg::ACK_OK,
  parameter logic [7:0] ACK_ERR        = osc_cmd_pkg::ACK_ERR
) (
  input  logic          clk,
  input  logic          rst,
  cmd_dispatch_if.slave bus,
  output logic          busy,
  output logic          err_unknown,
  output logic          err_timeout,
  output logic          rx_drop,
  output logic [15:0]   cmd_count,
  output logic [2:0]    state_o
);
  import osc_cmd_pkg::state_t;
  import osc_cmd_pkg::ST_IDLE;
  import osc_cmd_pkg::ST_DISPATCH;
  import osc_cmd_pkg::ST_RELEASE;
  import osc_cmd_pkg::ST_ABORT;
  import osc_cmd_pkg::ST_ACK;

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               reply_ok_q, reply_ok_d;
  logic               err_unknown_q, err_unknown_d;
  logic               rx_drop_q, rx_drop_d;
  logic [15:0]        cmd_count_q, cmd_count_d;

  logic [7:0]         op_off;
  logic               op_valid;
  logic               done_k;
  logic [N_SLOTS-1:0] slot_oh;
  logic               tmr_clr, tmr_en, tmr_expired;

  // Offset arithmetic wraps in 8 bits, so opcodes below the base decode invalid.
  assign op_off   = bus.rx_data - OPCODE_BASE;
  assign op_valid = (int'(op_off) < N_SLOTS);
  assign done_k   = bus.sub_done[slot_q];
  assign slot_oh  = N_SLOTS'(1) << slot_q;
  assign tmr_en   = (state_q == ST_DISPATCH) || (state_q == ST_RELEASE);

  cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    reply_ok_d    = reply_ok_q;
    cmd_count_d   = cmd_count_q;
    err_unknown_d = 1'b0;
    rx_drop_d     = 1'b0;
    tmr_clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_ready) begin
          if (op_valid) begin
            state_d = ST_DISPATCH;
            slot_d  = op_off[SLOT_W-1:0];
            tmr_clr = 1'b1;
          end else begin
            state_d       = ST_ACK;
            err_unknown_d = 1'b1;
            tx_data_d     = ACK_ERR;
            tx_valid_d    = 1'b1;
            reply_ok_d    = 1'b0;
          end
        end
      end
      ST_DISPATCH: begin
        tmr_clr = bus.rx_ready;
        // A slot finishing on the timeout cycle still counts as success.
        if (done_k) begin
          state_d = ST_RELEASE;
        end else if (tmr_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_RELEASE: begin
        rx_drop_d = bus.rx_ready;
        if (!done_k) begin
          state_d    = ST_ACK;
          tx_data_d  = ACK_OK;
          tx_valid_d = 1'b1;
          reply_ok_d = 1'b1;
        end else if (tmr_expired) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        rx_drop_d  = bus.rx_ready;
        state_d    = ST_ACK;
        tx_data_d  = ACK_ERR;
        tx_valid_d = 1'b1;
        reply_ok_d = 1'b0;
      end
      ST_ACK: begin
        rx_drop_d = bus.rx_ready;
        if (bus.tx_ready) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          if (reply_ok_q) begin
            cmd_count_d = cmd_count_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      slot_q        <= '0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      reply_ok_q    <= 1'b0;
      err_unknown_q <= 1'b0;
      rx_drop_q     <= 1'b0;
      cmd_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      reply_ok_q    <= reply_ok_d;
      err_unknown_q <= err_unknown_d;
      rx_drop_q     <= rx_drop_d;
      cmd_count_q   <= cmd_count_d;
    end
  end

  // Slot-facing outputs decode straight from the registered state.
  assign bus.sub_activate = (state_q == ST_DISPATCH) ? slot_oh : '0;
  assign bus.sub_rst_n    = (state_q == ST_ABORT) ? ~slot_oh : '1;
  assign bus.sub_rx_data  = (state_q == ST_DISPATCH) ? bus.rx_data : 8'h00;
  assign bus.sub_rx_ready = (state_q == ST_DISPATCH) && bus.rx_ready;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_valid     = tx_valid_q;

  assign busy        = (state_q != ST_IDLE);
  assign err_unknown = err_unknown_q;
  assign err_timeout = (state_q == ST_ABORT);
  assign rx_drop     = rx_drop_q;
  assign cmd_count   = cmd_count_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized self-checking bench for cmd_dispatch with a short timeout so
// abort paths are reachable.
module tb_cmd_dispatch;
  import osc_cmd_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        busy, err_unknown, err_timeout, rx_drop;
  logic [15:0] cmd_count;
  logic [2:0]  state_o;

  cmd_dispatch_if #(.N_SLOTS(N)) bus ();

  cmd_dispatch #(.N_SLOTS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_unknown (err_unknown),
    .err_timeout (err_timeout),
    .rx_drop     (rx_drop),
    .cmd_count   (cmd_count),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  int          exp_count = 0;
  int          fwd_cnt = 0, tmo_cnt = 0, unk_cnt = 0;
  int          cur_k = 0;
  bit          done_k = 1'b0;
  bit          held_v = 1'b0;
  logic [7:0]  held_d = 8'h00;
  logic [7:0]  mon_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] slot_mask(input int k);
    return 4'(1 << k);
  endfunction

  function automatic logic [7:0] rand_bad();
    logic [7:0] b;
    int bv;
    do begin
      b  = 8'($urandom);
      bv = b;
    end while (bv >= int'(OPCODE_BASE) && bv < int'(OPCODE_BASE) + N);
    return b;
  endfunction

  // Monitor: pulse counters, reply scoreboard, hold and one-hot checks.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.sub_rx_ready) fwd_cnt++;
      if (err_timeout) tmo_cnt++;
      if (err_unknown) unk_cnt++;
      check_eq("one_hot", 32'($countones(bus.sub_activate) <= 1), 1);
      if (held_v) check_eq("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, held_d});
      if (bus.tx_valid && bus.tx_ready) begin
        check_eq("reply_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("reply_byte", bus.tx_data, mon_e);
          if (mon_e == ACK_OK) exp_count++;
        end
      end
      held_v = bus.tx_valid && !bus.tx_ready;
      held_d = bus.tx_data;
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Slot done lines: bit cur_k follows done_k, the others carry noise.
  task automatic step();
    logic [3:0] m;
    m = slot_mask(cur_k);
    bus.sub_done = (4'($urandom) & ~m) | (done_k ? m : 4'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fwd);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    #1;
    check_eq("sub_rx_ready", bus.sub_rx_ready, fwd);
    if (fwd) check_eq("sub_rx_data", bus.sub_rx_data, b);
    step();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic wait_ack(input int hold, input bit drop);
    int n;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      step();
      n++;
    end
    check_eq("ack_seen", bus.tx_valid, 1);
    for (int i = 0; i < hold; i++) begin
      if (drop && i == 0) begin
        send_byte(8'h55, 1'b0);
        check_eq("rx_drop", rx_drop, 1);
      end else begin
        step();
      end
    end
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    check_eq("ack_done", {bus.tx_valid, busy}, 2'b00);
  endtask

  task automatic run_valid(input int k, input int nb, input bit stall, input int hold, input bit drop);
    logic [3:0] m, nm;
    int f0, early;
    m = slot_mask(k);
    nm = ~m;
    cur_k = k;
    done_k = 1'b0;
    f0 = fwd_cnt;
    exp_q.push_back(stall ? ACK_ERR : ACK_OK);
    send_byte(OPCODE_BASE + 8'(k), 1'b0);
    check_eq("activate", bus.sub_activate, m);
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 7)) step();
      send_byte(8'($urandom), 1'b1);
    end
    if (stall) begin
      early = 0;
      for (int i = 1; i < TMO; i++) begin
        step();
        if (err_timeout || bus.sub_activate != m) early++;
      end
      check_eq("no_early_abort", early, 0);
      step();
      check_eq("abort_pulse", {err_timeout, bus.sub_activate, bus.sub_rst_n}, {1'b1, 4'b0000, nm});
      step();
      check_eq("abort_len", {err_timeout, bus.sub_rst_n, bus.tx_valid}, {1'b0, 4'hF, 1'b1});
    end else begin
      repeat ($urandom_range(0, 7)) step();
      done_k = 1'b1;
      step();
      check_eq("release", {bus.sub_activate, state_o}, {4'b0000, ST_RELEASE});
      repeat ($urandom_range(0, 3)) step();
      done_k = 1'b0;
      step();
      check_eq("ack_valid", bus.tx_valid, 1);
    end
    check_eq("reply_now", bus.tx_data, exp_q[0]);
    check_eq("fwd_count", fwd_cnt - f0, nb);
    wait_ack(hold, drop);
    check_eq("cmd_count", cmd_count, 16'(exp_count));
  endtask

  task automatic run_invalid(input logic [7:0] b, input int hold, input bit drop);
    int u0;
    u0 = unk_cnt;
    cur_k = $urandom_range(0, N - 1);
    done_k = 1'b0;
    exp_q.push_back(ACK_ERR);
    send_byte(b, 1'b0);
    check_eq("err_unknown", {err_unknown, bus.sub_activate, bus.tx_valid, busy}, {1'b1, 4'b0000, 1'b1, 1'b1});
    check_eq("reply_err", bus.tx_data, exp_q[0]);
    wait_ack(hold, drop);
    check_eq("unk_pulses", unk_cnt - u0, 1);
    check_eq("cmd_count", cmd_count, 16'(exp_count));
  endtask

  // ---------------- main sequence ----------------
  int kind, hold, t0, f0;
  bit drop;

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.sub_done = 4'b0000;
    bus.tx_ready = 1'b0;

    repeat (3) step();
    check_eq("reset_vals",
             {bus.sub_activate, bus.sub_rst_n, bus.tx_valid, bus.tx_data, busy,
              err_unknown, err_timeout, rx_drop, cmd_count},
             {4'b0000, 4'hF, 1'b0, 8'h00, 1'b0, 3'b000, 16'h0000});
    rst = 1'b1;
    step();

    // Slot 0 as a trigger-config target: three payload bytes, then done.
    cur_k = 0;
    f0 = fwd_cnt;
    exp_q.push_back(8'hAA);
    send_byte(8'h01, 1'b0);
    check_eq("trig_activate", bus.sub_activate, 4'b0001);
    send_byte(8'h02, 1'b1);
    step();
    send_byte(8'h10, 1'b1);
    step();
    send_byte(8'hF0, 1'b1);
    step();
    done_k = 1'b1;
    step();
    step();
    done_k = 1'b0;
    step();
    check_eq("trig_reply", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hAA});
    check_eq("trig_fwd", fwd_cnt - f0, 3);
    wait_ack(1, 1'b0);
    check_eq("trig_count", cmd_count, 16'd1);

    run_invalid(8'h09, 0, 1'b0);
    run_valid(1, 0, 1'b1, 2, 1'b0);
    run_valid(2, 1, 1'b0, 3, 1'b1);

    // Done on the very cycle the window expires: success wins.
    cur_k = 3;
    t0 = tmo_cnt;
    exp_q.push_back(8'hAA);
    send_byte(8'h04, 1'b0);
    repeat (15) step();
    done_k = 1'b1;
    step();
    check_eq("coincide_rel", {err_timeout, bus.sub_activate, state_o}, {1'b0, 4'b0000, ST_RELEASE});
    done_k = 1'b0;
    step();
    check_eq("coincide_reply", {bus.tx_valid, bus.tx_data}, {1'b1, 8'hAA});
    wait_ack(1, 1'b0);
    check_eq("coincide_no_tmo", tmo_cnt - t0, 0);
    check_eq("coincide_count", cmd_count, 16'(exp_count));

    // Reset in the middle of a command.
    cur_k = 1;
    done_k = 1'b0;
    send_byte(8'h02, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    exp_count = 0;
    check_eq("midrst_vals",
             {bus.sub_activate, bus.sub_rst_n, bus.tx_valid, bus.tx_data, busy,
              err_unknown, err_timeout, rx_drop, cmd_count},
             {4'b0000, 4'hF, 1'b0, 8'h00, 1'b0, 3'b000, 16'h0000});
    rst = 1'b1;
    cur_k = 2;
    exp_q.push_back(8'hAA);
    send_byte(8'h03, 1'b0);
    check_eq("post_rst_act", bus.sub_activate, 4'b0100);
    done_k = 1'b1;
    step();
    done_k = 1'b0;
    step();
    wait_ack(0, 1'b0);
    check_eq("post_rst_count", cmd_count, 16'(exp_count));

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(0, 3);
      drop = (hold > 0) && ($urandom_range(0, 1) == 1);
      if (kind < 2) run_invalid(rand_bad(), hold, drop);
      else run_valid($urandom_range(0, N - 1), $urandom_range(0, 3), kind < 4, hold, drop);
    end

    repeat (3) step();
    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
